// File: rtl/mul_shift_add_16bit.sv
// 16x16 unsigned shift-and-add multiplier; one adder pass per cycle, 16 iterations,
// full 32-bit product with a START/BUSY/DONE handshake.

module full_adder_16bit (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        CIN,
  output logic [15:0] S,
  output logic        COUT
);
  assign {COUT, S} = {1'b0, A} + {1'b0, B} + {16'b0, CIN};
endmodule

// Handshake: START is accepted on a rising edge only while idle or in the DONE
// cycle (BUSY=0); BUSY then stays high for 16 cycles, and DONE pulses for one
// cycle with P/OVF already valid. START while BUSY=1 is ignored.
module mul_shift_add_16bit #(
  parameter int WIDTH = 16,
  parameter int ITERS = 16
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 START,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [2*WIDTH-1:0]   P,
  output logic                 OVF,
  output logic [1:0]           DBG_STATE
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DONE_S = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   mcand, acc_hi, acc_lo;
  logic [4:0]         cnt;
  logic [WIDTH-1:0]   add_b, sum;
  logic               cout;
  logic [2*WIDTH-1:0] shifted;
  logic               load, last;

  assign add_b     = acc_lo[0] ? mcand : '0;
  // The adder carry becomes the new ACC_HI MSB, so no product bit is lost.
  assign shifted   = {cout, sum, acc_lo[WIDTH-1:1]};
  assign DBG_STATE = state;

  full_adder_16bit u_add (
    .A    (acc_hi),
    .B    (add_b),
    .CIN  (1'b0),
    .S    (sum),
    .COUT (cout)
  );

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (START) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (cnt == 5'(ITERS - 1)) begin
          last      = 1'b1;
          state_nxt = DONE_S;
        end
      end
      DONE_S: begin
        load      = START;
        state_nxt = START ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state  <= IDLE;
      mcand  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      cnt    <= '0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      P      <= '0;
      OVF    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) begin
        mcand  <= A;
        acc_hi <= '0;
        acc_lo <= B;
        cnt    <= '0;
        BUSY   <= 1'b1;
        DONE   <= 1'b0;
      end else if (state == RUN) begin
        {acc_hi, acc_lo} <= shifted;
        cnt              <= cnt + 5'd1;
        if (last) begin
          P    <= shifted;
          OVF  <= |{cout, sum[WIDTH-1:1]};
          BUSY <= 1'b0;
          DONE <= 1'b1;
        end
      end else if (state == DONE_S) begin
        DONE <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mul_shift_add_16bit.sv
// Bench for mul_shift_add_16bit: directed cases plus random operations, checked
// against a plain a*b reference model through an expected-result queue.

module tb_mul_shift_add_16bit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a, b;
  logic        busy, done, ovf;
  logic [31:0] p;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  logic [32:0] exp_q[$];
  logic [32:0] hold_val;
  bit          mon_en;

  mul_shift_add_16bit dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .START     (start),
    .A         (a),
    .B         (b),
    .BUSY      (busy),
    .DONE      (done),
    .P         (p),
    .OVF       (ovf),
    .DBG_STATE (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference model: {ovf, product}
  function automatic logic [32:0] model(input logic [15:0] x, input logic [15:0] y);
    logic [31:0] prod;
    prod = 32'(x) * 32'(y);
    return {prod > 32'h0000_FFFF, prod};
  endfunction

  // scoreboard: completions pop the queue; otherwise P/OVF must hold
  always @(negedge clk) begin
    if (mon_en) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          check("spurious_done", {32'b0, done}, 33'd0);
        end else begin
          hold_val = exp_q.pop_front();
          check("product", {ovf, p}, hold_val);
        end
      end else begin
        check("p_hold", {ovf, p}, hold_val);
      end
    end
  end

  task automatic issue(input logic [15:0] x, input logic [15:0] y);
    start = 1'b1;
    a     = x;
    b     = y;
    exp_q.push_back(model(x, y));
    @(posedge clk); #1;
    check("busy_accept", {32'b0, busy}, 33'd1);
    check("done_accept", {32'b0, done}, 33'd0);
    start = 1'b0;
    a     = 16'($urandom);
    b     = 16'($urandom);
  endtask

  task automatic wait_done(input int expect_n);
    int n;
    n = 0;
    do begin
      if (n > 0 && n < expect_n) check("busy_run", {32'b0, busy}, 33'd1);
      @(posedge clk); #1;
      n++;
    end while (!done && n < 40);
    check("latency", 33'(n), 33'(expect_n));
    check("busy_end", {32'b0, busy}, 33'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    a        = '0;
    b        = '0;
    hold_val = '0;
    mon_en   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {32'b0, busy}, 33'd0);
    check("rst_done", {32'b0, done}, 33'd0);
    check("rst_p_ovf", {ovf, p}, 33'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // basic, carry-out and overflow cases
    issue(16'h0003, 16'h0005); wait_done(16);
    issue(16'hFFFF, 16'hFFFF); wait_done(16);
    issue(16'h8000, 16'h0002); wait_done(16);
    issue(16'h1234, 16'h0000); wait_done(16);
    repeat (2) @(posedge clk);
    #1;

    // START during RUN is ignored
    issue(16'h000F, 16'h0001);
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1; a = 16'hFFFF; b = 16'hFFFF;
    @(posedge clk); #1;
    check("busy_ignored", {32'b0, busy}, 33'd1);
    start = 1'b0;
    wait_done(13);
    repeat (3) @(posedge clk);
    #1;
    check("no_second_op", {32'b0, busy}, 33'd0);

    // reset mid-run aborts without DONE and clears P
    issue(16'hFFFF, 16'hFFFF);
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    hold_val = '0;
    check("abort_busy", {32'b0, busy}, 33'd0);
    check("abort_done", {32'b0, done}, 33'd0);
    check("abort_p", {ovf, p}, 33'd0);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;

    // back-to-back: START held in the DONE cycle
    issue(16'h0003, 16'h0005); wait_done(16);
    issue(16'h0007, 16'h0009); wait_done(16);
    @(posedge clk); #1;

    // random operations, sometimes back-to-back
    for (int i = 0; i < 30; i++) begin
      int gap;
      gap = $urandom_range(0, 3);
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
      case ($urandom_range(0, 3))
        0:       issue(16'hFFFF, 16'($urandom));
        1:       issue(16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)));
        default: issue(16'($urandom), 16'($urandom));
      endcase
      wait_done(16);
    end

    repeat (4) @(posedge clk);
    #1;
    check("queue_empty", 33'(exp_q.size()), 33'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
